decode_stage: RTL and testbench

- Registered, parametrised instruction decode stage with a register scoreboard and a valid/ready handshake on both sides.
- Sits between fetch and the ALU/regfile read stage. Produces the same control set as the combinational decoder: alu_func, alu_in2_mux, regno1, regno2, regfile_wrtEn, regfile_wrtRegno. Adds a sign-extended immediate.
- Tracks pending destination registers. Holds dependent instructions (RAW/WAW) until writeback clears them. Counts stall cycles.

---
 rtl/decode_stage.sv | 140 ++++++++++++++
 tb/tb_decode_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with a per-register pending
// scoreboard, RAW/WAW hazard hold, valid/ready handshakes on both sides and
// a saturating hazard-stall counter.
module decode_stage #(
    parameter int WORD_SIZE  = 32,
    parameter int REGNO_BITS = 4,
    parameter int FUNC_BITS  = 4,
    parameter int IMM_BITS   = 16,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FUNC_BITS:0]    out_alu_func,
    output logic                  out_alu_in2_mux,
    output logic [REGNO_BITS-1:0] out_regno1,
    output logic [REGNO_BITS-1:0] out_regno2,
    output logic                  out_regfile_wrtEn,
    output logic [REGNO_BITS-1:0] out_regfile_wrtRegno,
    output logic [WORD_SIZE-1:0]  out_imm,
    output logic                  out_illegal,
    input  logic                  wb_valid,
    input  logic [REGNO_BITS-1:0] wb_regno,
    output logic [CNT_BITS-1:0]   stall_count
);

    localparam int NREGS    = 2 ** REGNO_BITS;
    localparam int OP_LSB   = WORD_SIZE - 4;
    localparam int FUNC_LSB = OP_LSB - FUNC_BITS;
    localparam int RD_LSB   = FUNC_LSB - REGNO_BITS;
    localparam int RS1_LSB  = RD_LSB - REGNO_BITS;
    localparam int RS2_LSB  = RS1_LSB - REGNO_BITS;

    typedef enum logic [3:0] {
        OP_ALU_R = 4'b0000,
        OP_ALU_I = 4'b1000
    } opcode_e;

    // Raw instruction fields
    logic [3:0]            op;
    logic [FUNC_BITS-1:0]  func;
    logic [REGNO_BITS-1:0] rd, rs1, rs2;
    logic [IMM_BITS-1:0]   imm_field;

    assign op        = in_instr[WORD_SIZE-1:OP_LSB];
    assign func      = in_instr[FUNC_LSB +: FUNC_BITS];
    assign rd        = in_instr[RD_LSB +: REGNO_BITS];
    assign rs1       = in_instr[RS1_LSB +: REGNO_BITS];
    assign rs2       = in_instr[RS2_LSB +: REGNO_BITS];
    assign imm_field = in_instr[IMM_BITS-1:0];

    // Decoded control set for the instruction currently offered
    logic                  is_alu_r, is_alu_i, legal;
    logic                  dec_mux, dec_wrt_en;
    logic [REGNO_BITS-1:0] dec_regno2;
    logic [WORD_SIZE-1:0]  dec_imm;

    // Scoreboard and handshake state
    logic [NREGS-1:0]    pending;
    logic [NREGS-1:0]    clear_vec, set_vec, eff_pending;
    logic                hazard, accept;

    // Opcode decode into the downstream control set
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        is_alu_r   = 1'b0;
        is_alu_i   = 1'b0;
        dec_mux    = 1'b0;
        dec_regno2 = rs2;
        dec_imm    = '0;
        case (op)
            OP_ALU_R: is_alu_r = 1'b1;
            OP_ALU_I: begin
                is_alu_i   = 1'b1;
                dec_mux    = 1'b1;
                dec_regno2 = '0;
                dec_imm    = {{(WORD_SIZE-IMM_BITS){imm_field[IMM_BITS-1]}}, imm_field};
            end
            default: ;
        endcase
        legal      = is_alu_r | is_alu_i;
        dec_wrt_en = legal;
    end

    // Hazard detection against pending writes; a same-cycle writeback satisfies it
    always_comb begin
        clear_vec   = wb_valid ? (NREGS'(1) << wb_regno) : '0;
        eff_pending = pending & ~clear_vec;
        hazard      = in_valid & legal &
                      (eff_pending[rs1] | (is_alu_r & eff_pending[rs2]) | eff_pending[rd]);
        in_ready    = ~hazard & (~out_valid | out_ready);
        accept      = in_valid & in_ready;
        set_vec     = (accept & dec_wrt_en) ? (NREGS'(1) << rd) : '0;
    end

    // Output register: load on accept, drop valid when consumed, hold otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid            <= 1'b0;
            out_alu_func         <= '0;
            out_alu_in2_mux      <= 1'b0;
            out_regno1           <= '0;
            out_regno2           <= '0;
            out_regfile_wrtEn    <= 1'b0;
            out_regfile_wrtRegno <= '0;
            out_imm              <= '0;
            out_illegal          <= 1'b0;
        end else if (accept) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            out_valid            <= 1'b1;
            out_alu_func         <= {1'b0, func};
            out_alu_in2_mux      <= dec_mux;
            out_regno1           <= rs1;
            out_regno2           <= dec_regno2;
            out_regfile_wrtEn    <= dec_wrt_en;
            out_regfile_wrtRegno <= rd;
            out_imm              <= dec_imm;
            out_illegal          <= ~legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Scoreboard update; a set on the same register wins over a writeback clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= eff_pending | set_vec;
    end

    // Saturating count of cycles held by a register hazard
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             stall_count <= '0;
        else if (hazard && (stall_count != '1)) stall_count <= stall_count + CNT_BITS'(1);
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// Inputs change 1 ns after the rising edge and are checked once settled.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_func;
    logic        out_alu_in2_mux;
    logic [3:0]  out_regno1;
    logic [3:0]  out_regno2;
    logic        out_regfile_wrtEn;
    logic [3:0]  out_regfile_wrtRegno;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic        wb_valid;
    logic [3:0]  wb_regno;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_instr             (in_instr),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_alu_func         (out_alu_func),
        .out_alu_in2_mux      (out_alu_in2_mux),
        .out_regno1           (out_regno1),
        .out_regno2           (out_regno2),
        .out_regfile_wrtEn    (out_regfile_wrtEn),
        .out_regfile_wrtRegno (out_regfile_wrtRegno),
        .out_imm              (out_imm),
        .out_illegal          (out_illegal),
        .wb_valid             (wb_valid),
        .wb_regno             (wb_regno),
        .stall_count          (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_regno = '0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d exp 0", stall_count); end
        n_checks++; if (out_imm !== 32'd0 || out_regfile_wrtRegno !== 4'd0 || out_alu_func !== 5'd0) begin
            n_fail++; $display("FAIL reset_fields: imm %h rd %h func %h exp 0", out_imm, out_regfile_wrtRegno, out_alu_func); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_r();
        in_valid = 1'b1; in_instr = 32'h0312_8000;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alur_in_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL alur_valid: got %b exp 1", out_valid); end
        n_checks++; if (out_alu_func !== 5'd3 || out_alu_in2_mux !== 1'b0) begin
            n_fail++; $display("FAIL alur_func_mux: got %h/%b exp 3/0", out_alu_func, out_alu_in2_mux); end
        n_checks++; if (out_regno1 !== 4'd2 || out_regno2 !== 4'd8) begin
            n_fail++; $display("FAIL alur_regnos: got %h/%h exp 2/8", out_regno1, out_regno2); end
        n_checks++; if (out_regfile_wrtEn !== 1'b1 || out_regfile_wrtRegno !== 4'd1) begin
            n_fail++; $display("FAIL alur_wrt: got %b/%h exp 1/1", out_regfile_wrtEn, out_regfile_wrtRegno); end
        n_checks++; if (out_imm !== 32'd0 || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL alur_imm_ill: got %h/%b exp 0/0", out_imm, out_illegal); end
        // retire R1 while the output drains
        wb_valid = 1'b1; wb_regno = 4'd1;
        tick();
        wb_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alur_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_alu_i();
        in_valid = 1'b1; in_instr = 32'h8021_FFFE;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_alu_in2_mux !== 1'b1) begin
            n_fail++; $display("FAIL alui_valid_mux: got %b/%b exp 1/1", out_valid, out_alu_in2_mux); end
        n_checks++; if (out_regno1 !== 4'd1 || out_regno2 !== 4'd0 || out_regfile_wrtRegno !== 4'd2) begin
            n_fail++; $display("FAIL alui_regnos: got %h/%h/%h exp 1/0/2", out_regno1, out_regno2, out_regfile_wrtRegno); end
        n_checks++; if (out_imm !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL alui_imm: got %h exp fffffffe", out_imm); end
        n_checks++; if (out_regfile_wrtEn !== 1'b1 || out_alu_func !== 5'd0) begin
            n_fail++; $display("FAIL alui_wrt_func: got %b/%h exp 1/0", out_regfile_wrtEn, out_alu_func); end
        wb_valid = 1'b1; wb_regno = 4'd2;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_raw();
        in_valid = 1'b1; in_instr = 32'h0312_8000;    // writes R1
        tick();
        in_instr = 32'h8011_0005;                     // reads and writes R1
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_held: got %b exp 0", in_ready); end
        tick(); tick(); tick();
        wb_valid = 1'b1; wb_regno = 4'd1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_ready: got %b exp 1", in_ready); end
        n_checks++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL raw_stalls: got %0d exp 3", stall_count); end
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_imm !== 32'd5 || out_regno1 !== 4'd1 || out_regfile_wrtRegno !== 4'd1) begin
            n_fail++; $display("FAIL raw_accept: got v%b imm %h rs1 %h rd %h exp 1/5/1/1", out_valid, out_imm, out_regno1, out_regfile_wrtRegno); end
        // R1 must be pending again: a reader is refused
        in_valid = 1'b1; in_instr = 32'h0031_0000;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_set_wins: got %b exp 0", in_ready); end
        in_valid = 1'b0; wb_valid = 1'b1; wb_regno = 4'd1;
        tick();
        wb_valid = 1'b0;
        n_checks++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL raw_stall_hold: got %0d exp 3", stall_count); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_instr = 32'h0312_8000; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_instr = 32'h0543_6000;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_regno1 !== 4'd2 || out_alu_func !== 5'd3 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got v%b rs1 %h func %h rdy %b exp 1/2/3/0", i, out_valid, out_regno1, out_alu_func, in_ready); end
        end
        n_checks++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL bp_not_counted: got %0d exp 3", stall_count); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_alu_func !== 5'd5 || out_regno1 !== 4'd3 || out_regno2 !== 4'd6 || out_regfile_wrtRegno !== 4'd4) begin
            n_fail++; $display("FAIL bp_next: got %h/%h/%h/%h exp 5/3/6/4", out_alu_func, out_regno1, out_regno2, out_regfile_wrtRegno); end
        wb_valid = 1'b1; wb_regno = 4'd1;
        tick();
        wb_regno = 4'd4;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = 32'hF79A_B123;
        tick();
        in_instr = 32'h0129_0000;                     // reads R9, the illegal op's rd
        #1;
        n_checks++; if (out_illegal !== 1'b1 || out_regfile_wrtEn !== 1'b0) begin
            n_fail++; $display("FAIL ill_flags: got %b/%b exp 1/0", out_illegal, out_regfile_wrtEn); end
        n_checks++; if (out_alu_func !== 5'd7 || out_regfile_wrtRegno !== 4'd9 || out_regno1 !== 4'hA || out_regno2 !== 4'hB) begin
            n_fail++; $display("FAIL ill_fields: got %h/%h/%h/%h exp 7/9/a/b", out_alu_func, out_regfile_wrtRegno, out_regno1, out_regno2); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_pending: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_regno1 !== 4'd9 || out_illegal !== 1'b0 || out_regfile_wrtRegno !== 4'd2) begin
            n_fail++; $display("FAIL ill_reader: got %h/%b/%h exp 9/0/2", out_regno1, out_illegal, out_regfile_wrtRegno); end
        wb_valid = 1'b1; wb_regno = 4'd2;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        in_valid = 1'b1; in_instr = 32'h0050_0000;    // writes R5
        tick();
        in_instr = 32'h0065_0000;                     // reads R5
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stall_held: got %b exp 0", in_ready); end
        tick(); tick();
        n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d exp 5", stall_count); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || stall_count !== 16'd0 || out_regno1 !== 4'd0) begin
            n_fail++; $display("FAIL rst_async: got v%b cnt %0d rs1 %h exp 0/0/0", out_valid, stall_count, out_regno1); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_regno1 !== 4'd5 || out_regfile_wrtRegno !== 4'd6 || stall_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_reader: got v%b rs1 %h rd %h cnt %0d exp 1/5/6/0", out_valid, out_regno1, out_regfile_wrtRegno, stall_count); end
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_alu_i();
        test_raw();
        test_backpressure();
        test_illegal();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
